// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: control bus between the multicycle controller (master)
// and the ARM-subset datapath (slave).
interface mc_control_unit_if #(
  parameter int unsigned ALUCTL_W = 2
);
  logic [31:0]         Instr;
  logic [3:0]          ALUFlags;
  logic                PCWrite;
  logic                AdrSrc;
  logic                MemWrite;
  logic                IRWrite;
  logic [1:0]          ResultSrc;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [ALUCTL_W-1:0] ALUControl;
  logic [1:0]          ImmSrc;
  logic                RegWrite;
  logic [1:0]          RegSrc;
  logic [3:0]          Flags;
  logic [3:0]          state;
  logic                illegal;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, RegSrc, Flags, state, illegal
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, RegSrc, Flags, state, illegal
  );
endinterface

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle FSM controller for the ARM-subset datapath.
// Sequences fetch/decode/execute/memory/writeback over a shared ALU and a
// unified memory port, holds the NZCV flag file and evaluates conditions.
// Optional feature: define MC_BL_LINK_EN to make BL write the link register.
module mc_control_unit #(
  parameter int unsigned ALUCTL_W = 2,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_ORR = 2'd3;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } stateT;

  stateT            stateQ;
  stateT            stateD;
  logic [CNT_W-1:0] waitCnt;
  logic [3:0]       flagsQ;

  logic [3:0] cond;
  logic [1:0] op;
  logic       immBit;
  logic [3:0] cmd;
  logic       sBit;
  logic       uBit;
  logic [3:0] rd;

  logic       waitDone;
  logic       condEx;
  logic       cmdLegal;
  logic       isCmp;
  logic       isLogical;
  logic [1:0] cmdAluOp;
  logic       flagWrite;

  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic [1:0] resultSrc;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] immSrc;
  logic       regWrite;
  logic       illegalC;

  logic unusedInstrBits;

  assign cond   = bus.Instr[31:28];
  assign op     = bus.Instr[27:26];
  assign immBit = bus.Instr[25];
  assign cmd    = bus.Instr[24:21];
  assign sBit   = bus.Instr[20];
  assign uBit   = bus.Instr[23];
  assign rd     = bus.Instr[15:12];

  assign unusedInstrBits = ^{bus.Instr[19:16], bus.Instr[11:0]};

  assign waitDone = (waitCnt == CNT_W'(MEM_LAT - 1));

  // Condition evaluation against the registered flags (N Z C V = 3..0)
  always_comb begin
    condEx = 1'b0;
    case (cond)
      4'b0000: condEx = flagsQ[2];
      4'b0001: condEx = ~flagsQ[2];
      4'b0010: condEx = flagsQ[1];
      4'b0011: condEx = ~flagsQ[1];
      4'b0100: condEx = flagsQ[3];
      4'b0101: condEx = ~flagsQ[3];
      4'b0110: condEx = flagsQ[0];
      4'b0111: condEx = ~flagsQ[0];
      4'b1000: condEx = flagsQ[1] & ~flagsQ[2];
      4'b1001: condEx = ~flagsQ[1] | flagsQ[2];
      4'b1010: condEx = (flagsQ[3] == flagsQ[0]);
      4'b1011: condEx = (flagsQ[3] != flagsQ[0]);
      4'b1100: condEx = ~flagsQ[2] & (flagsQ[3] == flagsQ[0]);
      4'b1101: condEx = flagsQ[2] | (flagsQ[3] != flagsQ[0]);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  // Data-processing command decode; MOV uses ORR with Rn read as the B pass-through
  always_comb begin
    cmdLegal  = 1'b1;
    isCmp     = 1'b0;
    isLogical = 1'b0;
    cmdAluOp  = ALU_ADD;
    case (cmd)
      4'b0100: cmdAluOp = ALU_ADD;
      4'b0010: cmdAluOp = ALU_SUB;
      4'b1010: begin
        cmdAluOp = ALU_SUB;
        isCmp    = 1'b1;
      end
      4'b0000: begin
        cmdAluOp  = ALU_AND;
        isLogical = 1'b1;
      end
      4'b1100, 4'b1101: begin
        cmdAluOp  = ALU_ORR;
        isLogical = 1'b1;
      end
      default: cmdLegal = 1'b0;
    endcase
  end

  // Next-state and Moore outputs; reset squashes every enable in its cycle
  always_comb begin
    stateD    = stateQ;
    pcWrite   = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = ALU_ADD;
    immSrc    = 2'b00;
    regWrite  = 1'b0;
    illegalC  = 1'b0;
    case (stateQ)
      FETCH: begin
        adrSrc    = 1'b0;
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        aluOp     = ALU_ADD;
        resultSrc = 2'b10;
        if (waitDone) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          stateD  = DECODE;
        end
      end
      DECODE: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        case (op)
          2'b01: stateD = MEMADR;
          2'b00: begin
            if (!cmdLegal) begin
              stateD   = FETCH;
              illegalC = 1'b1;
            end else begin
              stateD = immBit ? EXECI : EXECR;
            end
          end
          2'b10: begin
            stateD = BRANCH;
`ifdef MC_BL_LINK_EN
            if (bus.Instr[24]) regWrite = condEx;
`endif
          end
          default: begin
            stateD   = FETCH;
            illegalC = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        aluSrcA = 1'b0;
        aluSrcB = 2'b01;
        immSrc  = 2'b01;
        aluOp   = uBit ? ALU_ADD : ALU_SUB;
        stateD  = sBit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adrSrc = 1'b1;
        if (waitDone) stateD = MEMWB;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = condEx;
        pcWrite   = condEx && (rd == 4'd15);
        stateD    = FETCH;
      end
      MEMWR: begin
        adrSrc   = 1'b1;
        memWrite = condEx;
        stateD   = FETCH;
      end
      EXECR: begin
        aluSrcA = 1'b0;
        aluSrcB = 2'b00;
        aluOp   = cmdAluOp;
        stateD  = isCmp ? FETCH : ALUWB;
      end
      EXECI: begin
        aluSrcA = 1'b0;
        aluSrcB = 2'b01;
        immSrc  = 2'b00;
        aluOp   = cmdAluOp;
        stateD  = isCmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        resultSrc = 2'b00;
        regWrite  = condEx;
        pcWrite   = condEx && (rd == 4'd15);
        stateD    = FETCH;
      end
      BRANCH: begin
        aluSrcA   = 1'b0;
        aluSrcB   = 2'b01;
        immSrc    = 2'b10;
        resultSrc = 2'b10;
        pcWrite   = condEx;
        stateD    = FETCH;
      end
      default: stateD = FETCH;
    endcase
    if (reset) begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      memWrite = 1'b0;
      regWrite = 1'b0;
      illegalC = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) stateQ <= FETCH;
    else       stateQ <= stateD;
  end

  // Wait counter, cleared whenever the state changes
  always_ff @(posedge clk) begin
    if (reset)                waitCnt <= '0;
    else if (stateD != stateQ) waitCnt <= '0;
    else                      waitCnt <= waitCnt + CNT_W'(1);
  end

  // NZCV flag file; logical ops refresh only N and Z
  assign flagWrite = ((stateQ == EXECR) || (stateQ == EXECI)) && (sBit || isCmp) && condEx;

  always_ff @(posedge clk) begin
    if (reset)          flagsQ <= 4'b0000;
    else if (flagWrite) flagsQ <= isLogical ? {bus.ALUFlags[3:2], flagsQ[1:0]} : bus.ALUFlags;
  end

  assign bus.PCWrite    = pcWrite;
  assign bus.AdrSrc     = adrSrc;
  assign bus.MemWrite   = memWrite;
  assign bus.IRWrite    = irWrite;
  assign bus.ResultSrc  = resultSrc;
  assign bus.ALUSrcA    = aluSrcA;
  assign bus.ALUSrcB    = aluSrcB;
  assign bus.ALUControl = ALUCTL_W'(aluOp);
  assign bus.ImmSrc     = immSrc;
  assign bus.RegWrite   = regWrite;
  assign bus.RegSrc     = (op == 2'b10) ? 2'b01 : ((op == 2'b01) && !sBit) ? 2'b10 : 2'b00;
  assign bus.Flags      = flagsQ;
  assign bus.state      = 4'(stateQ);
  assign bus.illegal    = illegalC;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed checks of the multicycle controller at
// MEM_LAT = 1 (instance A) and MEM_LAT = 3 (instance B).
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic resetA;
  logic resetB;
  int   checks = 0;
  int   failures = 0;

  mc_control_unit_if #(.ALUCTL_W(2)) busA ();
  mc_control_unit_if #(.ALUCTL_W(2)) busB ();

  mc_control_unit #(.ALUCTL_W(2), .MEM_LAT(1)) dutA (
    .clk   (clk),
    .reset (resetA),
    .bus   (busA)
  );

  mc_control_unit #(.ALUCTL_W(2), .MEM_LAT(3)) dutB (
    .clk   (clk),
    .reset (resetB),
    .bus   (busB)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Guard against a hung run
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic blRegWrite;
`ifdef MC_BL_LINK_EN
    blRegWrite = 1'b1;
`else
    blRegWrite = 1'b0;
`endif
    resetA = 1'b1;
    resetB = 1'b1;
    busA.Instr    = 32'hE2821005;
    busA.ALUFlags = 4'b0000;
    busB.Instr    = 32'hE5943004;
    busB.ALUFlags = 4'b0000;

    // Reset state (FETCH with counter at 0 would otherwise fetch)
    step;
    chk("rst_state", busA.state, 0);
    chk("rst_flags", busA.Flags, 4'b0000);
    chk("rst_pcwrite", busA.PCWrite, 0);
    chk("rst_irwrite", busA.IRWrite, 0);
    chk("rst_illegal", busA.illegal, 0);

    // ADD R1,R2,#5
    resetA = 1'b0;
    #1;
    chk("add_c1_state", busA.state, 0);
    chk("add_c1_irwrite", busA.IRWrite, 1);
    chk("add_c1_pcwrite", busA.PCWrite, 1);
    chk("add_c1_regwrite", busA.RegWrite, 0);
    step;
    chk("add_c2_state", busA.state, 1);
    chk("add_c2_regwrite", busA.RegWrite, 0);
    step;
    chk("add_c3_state", busA.state, 7);
    chk("add_c3_alusrcb", busA.ALUSrcB, 2'b01);
    chk("add_c3_aluctl", busA.ALUControl, 0);
    chk("add_c3_regwrite", busA.RegWrite, 0);
    step;
    chk("add_c4_state", busA.state, 8);
    chk("add_c4_regwrite", busA.RegWrite, 1);
    chk("add_c4_pcwrite", busA.PCWrite, 0);
    step;
    chk("add_done_state", busA.state, 0);
    chk("add_flags", busA.Flags, 4'b0000);

    // SUBS R0,R0,R0 -> Z set
    busA.Instr = 32'hE0500000;
    step;
    chk("subs_decode", busA.state, 1);
    step;
    chk("subs_execr", busA.state, 6);
    chk("subs_aluctl", busA.ALUControl, 1);
    busA.ALUFlags = 4'b0100;
    step;
    chk("subs_aluwb", busA.state, 8);
    chk("subs_flags", busA.Flags, 4'b0100);
    step;

    // BEQ taken
    busA.Instr = 32'h0A000000;
    step;
    step;
    chk("beq_state", busA.state, 9);
    chk("beq_pcwrite", busA.PCWrite, 1);
    chk("beq_immsrc", busA.ImmSrc, 2'b10);
    chk("beq_regsrc", busA.RegSrc, 2'b01);
    step;

    // BNE not taken
    busA.Instr = 32'h1A000000;
    step;
    step;
    chk("bne_state", busA.state, 9);
    chk("bne_pcwrite", busA.PCWrite, 0);
    step;

    // STR NE while Z = 1: MEMWR with no write
    busA.Instr = 32'h15843004;
    chk("strne_fetch", busA.state, 0);
    step;
    step;
    chk("strne_memadr", busA.state, 2);
    chk("strne_regsrc", busA.RegSrc, 2'b10);
    chk("strne_immsrc", busA.ImmSrc, 2'b01);
    chk("strne_memwrite_adr", busA.MemWrite, 0);
    step;
    chk("strne_memwr", busA.state, 5);
    chk("strne_memwrite", busA.MemWrite, 0);
    step;

    // ANDS: N,Z update, C,V hold
    busA.Instr = 32'hE0100001;
    step;
    step;
    chk("ands_execr", busA.state, 6);
    chk("ands_aluctl", busA.ALUControl, 2);
    busA.ALUFlags = 4'b1011;
    step;
    chk("ands_flags", busA.Flags, 4'b1000);
    step;

    // BNE now taken (Z = 0)
    busA.Instr = 32'h1A000000;
    step;
    step;
    chk("bne2_pcwrite", busA.PCWrite, 1);
    step;

    // Illegal opcode Op = 11
    busA.Instr = 32'hEC000000;
    step;
    chk("ill_decode", busA.state, 1);
    chk("ill_pulse", busA.illegal, 1);
    chk("ill_regwrite", busA.RegWrite, 0);
    chk("ill_pcwrite", busA.PCWrite, 0);
    chk("ill_memwrite", busA.MemWrite, 0);
    step;
    chk("ill_next", busA.state, 0);
    chk("ill_clear", busA.illegal, 0);

    // STR AL, then reset while in MEMWR
    busA.Instr = 32'hE5843004;
    step;
    step;
    step;
    chk("str_memwr", busA.state, 5);
    chk("str_memwrite", busA.MemWrite, 1);
    resetA = 1'b1;
    #1;
    chk("rstmid_memwrite", busA.MemWrite, 0);
    step;
    chk("rstmid_state", busA.state, 0);
    chk("rstmid_flags", busA.Flags, 4'b0000);
    resetA = 1'b0;

    // LDR R3,[R4,#4] with MEM_LAT = 3: 9 cycles
    resetB = 1'b0;
    #1;
    chk("ldr_c1_state", busB.state, 0);
    chk("ldr_c1_irwrite", busB.IRWrite, 0);
    step;
    chk("ldr_c2_irwrite", busB.IRWrite, 0);
    step;
    chk("ldr_c3_state", busB.state, 0);
    chk("ldr_c3_irwrite", busB.IRWrite, 1);
    chk("ldr_c3_pcwrite", busB.PCWrite, 1);
    step;
    chk("ldr_c4_state", busB.state, 1);
    step;
    chk("ldr_c5_state", busB.state, 2);
    chk("ldr_c5_aluctl", busB.ALUControl, 0);
    step;
    chk("ldr_c6_state", busB.state, 3);
    chk("ldr_c6_adrsrc", busB.AdrSrc, 1);
    step;
    chk("ldr_c7_state", busB.state, 3);
    step;
    chk("ldr_c8_state", busB.state, 3);
    step;
    chk("ldr_c9_state", busB.state, 4);
    chk("ldr_c9_regwrite", busB.RegWrite, 1);
    chk("ldr_c9_resultsrc", busB.ResultSrc, 2'b01);
    chk("ldr_c9_pcwrite", busB.PCWrite, 0);
    step;
    chk("ldr_done_state", busB.state, 0);

    // BL: link write only with the link feature enabled
    busB.Instr = 32'hEB000000;
    step;
    step;
    step;
    chk("bl_decode", busB.state, 1);
    chk("bl_regwrite", busB.RegWrite, 32'(blRegWrite));
    step;
    chk("bl_branch", busB.state, 9);
    chk("bl_pcwrite", busB.PCWrite, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
